dct_butterfly: RTL and testbench
================================

# dct_butterfly

Input stage of the Dct2 pipeline, placed directly upstream of the Rotate stages. It collects a serial stream of N samples per vector into a ping-pong buffer. For each vector it emits N/2 pairs: the sum and difference of mirror-indexed samples (x[i]+x[N-1-i], x[i]-x[N-1-i]), in i order. The output pairs map one-to-one onto a downstream Rotate stage's x1/x2 inputs.

## Interface
- Width, 16: sample and output word width, signed two's complement.
- N, 8: samples per vector. Must be even, a power of two, and at least 2.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; asynchronous and active-high.
- s_ready_o  out  1  input can accept a sample.
- s_valid_i  in  1  input sample valid.
- s_data_i  in  Width  signed input sample. Beats are numbered 0..N-1 within a vector by an internal counter; there is no last input.
- m_ready_i  in  1  downstream accepts the output pair.
- m_valid_o  out  1  output pair valid.
- m_y1_o  out  Width  signed sum x[i]+x[N-1-i].
- m_y2_o  out  Width  signed difference x[i]-x[N-1-i].
- m_index_o  out  $clog2(N/2), minimum 1  pair index i, from 0 to N/2-1.
- m_last_o  out  1  high when m_index_o = N/2-1.

## Operation
- Storage is two banks (0 and 1) of N×Width each, with one full flag per bank.
- **Write side:**
  - State is wr_bank and wr_cnt (0..N-1).
  - s_ready_o = !full[wr_bank], driven only from registered state, with no combinational path from m_ready_i.
  - On each input handshake, store s_data_i at bank[wr_bank][wr_cnt] and increment wr_cnt.
  - On the beat where wr_cnt = N-1: set full[wr_bank], wrap wr_cnt to 0, and toggle wr_bank.
- **Read side:**
  - State is rd_bank and rd_cnt (0..N/2-1), plus a registered output stage.
  - The output stage loads when (!m_valid_o || m_ready_i) && full[rd_bank]. The load:
    - sets m_y1_o = bank[x[rd_cnt]] + bank[x[N-1-rd_cnt]];
    - sets m_y2_o = x[rd_cnt] - x[N-1-rd_cnt];
    - sets m_index_o = rd_cnt and m_last_o = (rd_cnt = N/2-1);
    - sets m_valid_o = 1 and increments rd_cnt.
  - A load with rd_cnt = N/2-1 also clears full[rd_bank], wraps rd_cnt to 0, and toggles rd_bank.
  - If m_ready_i is high and no full bank is available, m_valid_o drops to 0.
  - While m_valid_o && !m_ready_i, all m_* outputs are held stable.
- **Arithmetic:** Width-bit adds and subtracts with two's complement wrap-around and no saturation. This matches the Rotate stage's Add semantics.
- **Set/clear on the same edge:** the writer can only target a non-full bank, and the reader only clears a full bank. Both flags may therefore change on the same edge without conflict.
- **Bank release:** a bank is released when its last pair is loaded into the output stage.
  - The writer may fill that bank from the next cycle onward.
  - This is safe because the output register already holds the last pair.
- **Reset:** asserting rst_i at any time discards partial and buffered vectors.
  - Outputs after reset: s_ready_o=1, m_valid_o=0, m_y1_o=0, m_y2_o=0, m_index_o=0, m_last_o=0.
  - State after reset: wr_cnt=rd_cnt=0, wr_bank=rd_bank=0, full flags=0.
  - Bank contents need no reset.

## Timing
- **Latency:** if sample N-1 of a vector is accepted at edge t and the output stage is free, pair 0 is presented with m_valid_o=1 after edge t+1.
- **Pair cadence:** pairs 1..N/2-1 follow on consecutive cycles while m_ready_i is high.
- **Throughput:** with m_ready_i held high, the block accepts one sample per cycle indefinitely and s_ready_o never deasserts, because N/2 output cycles ≤ N input cycles.
- **Backpressure:** with m_ready_i held low, the block accepts 2N samples (both banks), then holds s_ready_o=0.
- **Recovery after backpressure:** s_ready_o rises in the cycle after the stalled bank's final pair loads into the output register.
- **Handshake rules:**
  - m_valid_o never deasserts without a handshake.
  - Vectors are emitted in arrival order.

## Test plan
- **Ramp vector:** N=8, Width=16, m_ready_i=1, input 1,2,…,8 on 8 consecutive cycles.
  - Output pairs in order: (9,-7) idx0, (9,-5) idx1, (9,-3) idx2, (9,-1) idx3, with m_last_o set on idx3 only.
  - m_valid_o rises one cycle after the 8th accept.
- **Wrap arithmetic:**
  - x0=32767, x7=1 -> idx0 outputs y1=-32768, y2=32766.
  - x0=-32768, x7=1 -> y2=32767.
- **Backpressure:** m_ready_i=0, stream 24 samples with s_valid_i=1.
  - Exactly 16 samples are accepted; s_ready_o is 0 from the cycle after the 16th.
  - idx0 of vector A is held stable throughout the stall.
  - After m_ready_i=1: vectors A then B then C are emitted in order, and s_ready_o returns to 1.
- **Reset mid-vector:** accept 5 samples, pulse rst_i asynchronously between edges.
  - All outputs take their reset values immediately and no output is produced for the partial vector.
  - A following ramp vector produces exactly the scenario 1 results.
- **Streaming:** continuous s_valid_i and m_ready_i for 100 vectors.
  - s_ready_o stays 1 throughout.
  - Exactly 400 pairs are produced, with no gaps after the first vector completes.
- **Random handshakes:** 1000 vectors with random data and random s_valid_i/m_ready_i.
  - Every pair and index matches a reference model.
  - No output changes while m_valid_o && !m_ready_i.

Source files
------------

// File: rtl/dct_butterfly.sv
// Dct2 input stage: ping-pong buffers a serial vector of N samples and emits
// the N/2 mirror-index sum/difference pairs that feed the Rotate stages.
module dct_butterfly #(
  parameter int unsigned Width = 16,
  parameter int unsigned N     = 8,
  localparam int unsigned IdxW = (N > 2) ? $clog2(N / 2) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic                    s_ready_o,
  input  logic                    s_valid_i,
  input  logic signed [Width-1:0] s_data_i,
  input  logic                    m_ready_i,
  output logic                    m_valid_o,
  output logic signed [Width-1:0] m_y1_o,
  output logic signed [Width-1:0] m_y2_o,
  output logic [IdxW-1:0]         m_index_o,
  output logic                    m_last_o
);

  localparam int unsigned CntW = $clog2(N);
  localparam logic [CntW-1:0] LastBeat = CntW'(N - 1);
  localparam logic [IdxW-1:0] LastPair = IdxW'(N / 2 - 1);

  logic [Width-1:0] mem_q [2][N];

  logic            wr_bank_q, wr_bank_d;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
  logic            rd_bank_q, rd_bank_d;
  logic [IdxW-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]      full_q, full_d;

  logic                    valid_q, valid_d;
  logic signed [Width-1:0] y1_q, y1_d;
  logic signed [Width-1:0] y2_q, y2_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    last_q, last_d;

  logic                    s_hs;
  logic                    load;
  logic signed [Width-1:0] x_lo, x_hi;

  // Ready depends on registered state only, so no path from m_ready_i.
  assign s_ready_o = !full_q[wr_bank_q];
  assign s_hs      = s_valid_i && s_ready_o;
  assign load      = (!valid_q || m_ready_i) && full_q[rd_bank_q];

  assign x_lo = mem_q[rd_bank_q][CntW'(rd_cnt_q)];
  assign x_hi = mem_q[rd_bank_q][LastBeat - CntW'(rd_cnt_q)];

  assign m_valid_o = valid_q;
  assign m_y1_o    = y1_q;
  assign m_y2_o    = y2_q;
  assign m_index_o = idx_q;
  assign m_last_o  = last_q;

  always_ff @(posedge clk_i) begin
    if (s_hs) begin
      mem_q[wr_bank_q][wr_cnt_q] <= s_data_i;
    end
  end

  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_bank_d = rd_bank_q;
    rd_cnt_d  = rd_cnt_q;
    full_d    = full_q;
    valid_d   = valid_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    idx_d     = idx_q;
    last_d    = last_q;

    if (s_hs) begin
      if (wr_cnt_q == LastBeat) begin
        wr_cnt_d          = '0;
        wr_bank_d         = ~wr_bank_q;
        full_d[wr_bank_q] = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + CntW'(1);
      end
    end

    // Writer only targets a non-full bank, so this clear never collides with the set above.
    if (load) begin
      y1_d    = x_lo + x_hi;
      y2_d    = x_lo - x_hi;
      idx_d   = rd_cnt_q;
      last_d  = (rd_cnt_q == LastPair);
      valid_d = 1'b1;
      if (rd_cnt_q == LastPair) begin
        rd_cnt_d          = '0;
        rd_bank_d         = ~rd_bank_q;
        full_d[rd_bank_q] = 1'b0;
      end else begin
        rd_cnt_d = rd_cnt_q + IdxW'(1);
      end
    end else if (m_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
      full_q    <= '0;
      valid_q   <= 1'b0;
      y1_q      <= '0;
      y2_q      <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
      full_q    <= full_d;
      valid_q   <= valid_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_dct_butterfly.sv
// Scoreboard bench for dct_butterfly: a vector-level model queues expected pairs,
// an output monitor pops and compares on every output handshake.
module tb_dct_butterfly;

  localparam int Width = 16;
  localparam int N     = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    s_ready;
  logic                    s_valid = 1'b0;
  logic signed [Width-1:0] s_data = '0;
  logic                    m_ready = 1'b0;
  logic                    m_valid;
  logic signed [Width-1:0] m_y1, m_y2;
  logic [1:0]              m_index;
  logic                    m_last;

  dct_butterfly #(.Width(Width), .N(N)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .s_ready_o(s_ready),
    .s_valid_i(s_valid),
    .s_data_i (s_data),
    .m_ready_i(m_ready),
    .m_valid_o(m_valid),
    .m_y1_o   (m_y1),
    .m_y2_o   (m_y2),
    .m_index_o(m_index),
    .m_last_o (m_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y1;
    int y2;
    int idx;
    int last;
  } pair_t;

  pair_t exp_q[$];
  int    cur_vec[$];
  int    tests = 0;
  int    fails = 0;
  int    acc_cnt = 0;
  int    pair_cnt = 0;
  int    gap_cnt = 0;

  logic        hold_prev = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_last = 1'b0;
  logic [31:0] hold_y;
  logic [3:0]  hold_tag;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int wrap16(input int v);
    logic signed [15:0] w;
    w = v[15:0];
    return int'(w);
  endfunction

  // Reference model: whole vectors become N/2 mirror pairs in arrival order.
  always @(negedge clk) begin
    if (!rst && s_valid && s_ready) begin
      acc_cnt++;
      cur_vec.push_back(int'(s_data));
      if (cur_vec.size() == N) begin
        for (int i = 0; i < N / 2; i++) begin
          pair_t p;
          p.y1   = wrap16(cur_vec[i] + cur_vec[N-1-i]);
          p.y2   = wrap16(cur_vec[i] - cur_vec[N-1-i]);
          p.idx  = i;
          p.last = (i == N / 2 - 1) ? 1 : 0;
          exp_q.push_back(p);
        end
        cur_vec.delete();
      end
    end
  end

  always @(posedge rst) begin
    cur_vec.delete();
    exp_q.delete();
    hold_prev  = 1'b0;
    prev_valid = 1'b0;
    prev_last  = 1'b0;
  end

  // Output monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_prev) begin
        check("hold_y1y2", {m_y1, m_y2}, hold_y);
        check("hold_tag", {28'd0, m_index, m_last, m_valid}, {28'd0, hold_tag});
      end
      if (prev_valid && !prev_last && !m_valid) gap_cnt++;
      if (m_valid && m_ready) begin
        pair_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pair: got idx %0d, expected no output", m_index);
        end else begin
          pair_t p;
          p = exp_q.pop_front();
          check("y1", m_y1, p.y1);
          check("y2", m_y2, p.y2);
          check("index", m_index, p.idx);
          check("last", m_last, p.last);
        end
      end
      hold_prev  = m_valid && !m_ready;
      hold_y     = {m_y1, m_y2};
      hold_tag   = {m_index, m_last, m_valid};
      prev_valid = m_valid;
      prev_last  = m_last;
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic send(input int d);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d[15:0];
    @(negedge clk);
    while (!s_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got s_ready 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 2000) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic send_ramp();
    for (int i = 1; i <= N; i++) send(i);
  endtask

  initial begin
    int a0, p0, low;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_y1", m_y1, 0);
    check("rst_y2", m_y2, 0);
    check("rst_index", m_index, 0);
    check("rst_last", m_last, 0);

    // Ramp vector
    m_ready = 1'b1;
    p0 = pair_cnt;
    send_ramp();
    check("ramp_valid_early", m_valid, 0);
    @(posedge clk);
    #1;
    check("ramp_valid_rise", m_valid, 1);
    check("ramp_y1_0", m_y1, 9);
    check("ramp_y2_0", m_y2, -7);
    drain();
    check("ramp_pairs", pair_cnt - p0, 4);

    // Wrap-around arithmetic
    send(32767);
    for (int i = 1; i < N - 1; i++) send(int'($urandom));
    send(1);
    send(-32768);
    for (int i = 1; i < N - 1; i++) send(int'($urandom));
    send(1);
    drain();

    // Backpressure: both banks fill, then s_ready drops
    m_ready = 1'b0;
    a0 = acc_cnt;
    p0 = pair_cnt;
    s_valid = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (k == 15) check("bp_ready_before_16", s_ready, 1);
      if (k == 16) check("bp_ready_after_16", s_ready, 0);
      s_data = 16'($urandom);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check("bp_accepted", acc_cnt - a0, 16);
    check("bp_ready_stall", s_ready, 0);
    check("bp_valid_held", m_valid, 1);
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) send(int'($urandom));
    drain();
    check("bp_pairs", pair_cnt - p0, 12);
    check("bp_ready_recover", s_ready, 1);

    // Asynchronous reset mid-vector
    p0 = pair_cnt;
    for (int i = 0; i < 5; i++) send(100 + i);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_s_ready", s_ready, 1);
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_y1", m_y1, 0);
    check("mid_rst_index", m_index, 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_no_pairs", pair_cnt - p0, 0);
    send_ramp();
    @(posedge clk);
    #1;
    check("mid_rst_ramp_y1", m_y1, 9);
    check("mid_rst_ramp_y2", m_y2, -7);
    drain();
    check("mid_rst_ramp_pairs", pair_cnt - p0, 4);

    // Streaming: 100 back-to-back vectors
    a0  = acc_cnt;
    p0  = pair_cnt;
    low = 0;
    s_valid = 1'b1;
    for (int k = 0; k < 100 * N; k++) begin
      if (!s_ready) low++;
      s_data = 16'($urandom);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    drain();
    check("stream_ready_low_cycles", low, 0);
    check("stream_accepted", acc_cnt - a0, 100 * N);
    check("stream_pairs", pair_cnt - p0, 400);

    // Random handshakes: 1000 vectors
    a0 = acc_cnt;
    for (int k = 0; k < 40000; k++) begin
      if (acc_cnt - a0 == 1000 * N) break;
      s_valid = ($urandom_range(3) != 0);
      s_data  = 16'($urandom);
      m_ready = $urandom_range(1);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    check("rand_accepted", acc_cnt - a0, 1000 * N);
    drain();
    check("partial_vector_empty", cur_vec.size(), 0);
    check("no_gaps_in_vector", gap_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
